// File: rtl/con_arb_cm.sv
// Round-robin arbiter/sequencer sharing the console dispatch controller between
// up to four requesters, with bounded retry on error and a watchdog timeout.
module con_arb_cm #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned TIMEOUT   = 1023,
  parameter int unsigned MAX_RETRY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*ADDR_W-1:0]   im_req_addr,
  output logic [N_REQ-1:0]          o_ack,
  output logic [N_REQ-1:0]          o_err,
  output logic                      o_timeout,
  output logic                      o_busy,
  output logic [1:0]                o_grant_id,
  output logic                      o_start_con,
  output logic [ADDR_W-1:0]         om_base_addr,
  input  logic                      i_done_con,
  input  logic                      i_error_con
);

  localparam int unsigned ID_W = 2;
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RC_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RETRY = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q,     state_d;
  logic [ID_W-1:0]     grant_q,     grant_d;
  logic [ID_W-1:0]     last_q,      last_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic                start_q,     start_d;
  logic [N_REQ-1:0]    ack_q,       ack_d;
  logic [N_REQ-1:0]    err_q,       err_d;
  logic                to_q,        to_d;
  logic                busy_q,      busy_d;
  logic [RC_W-1:0]     retry_q,     retry_d;
  logic [WD_W-1:0]     wd_q,        wd_d;
  logic                gap_q,       gap_d;
  logic                resp_ok_q,   resp_ok_d;
  logic                resp_to_q,   resp_to_d;

  // Round-robin pick: first set request after the last granted id
  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     pick_idx;
  logic [ADDR_W-1:0]   pick_addr;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      pick_idx = ID_W'((32'(last_q) + i) % N_REQ);
      if (!pick_found && i_req[pick_idx]) begin
        pick_found = 1'b1;
        pick_id    = pick_idx;
      end
    end
  end

  assign pick_addr = im_req_addr[32'(pick_id) * ADDR_W +: ADDR_W];

  // Saturating watchdog; expiry is flagged on the cycle it would reach TIMEOUT
  logic [WD_W-1:0] wd_inc;
  logic            wd_expire;

  assign wd_inc    = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
  assign wd_expire = (32'(wd_q) + 32'd1) >= TIMEOUT;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    start_d   = 1'b0;
    ack_d     = '0;
    err_d     = '0;
    to_d      = 1'b0;
    retry_d   = retry_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    resp_ok_d = resp_ok_q;
    resp_to_d = resp_to_q;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_id;
          addr_d  = pick_addr;
          start_d = 1'b1;
          retry_d = '0;
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        wd_d = wd_inc;
        if (i_done_con) begin
          resp_ok_d = 1'b1;
          resp_to_d = 1'b0;
          state_d   = S_RESP;
        end else if (i_error_con && (32'(retry_q) < MAX_RETRY)) begin
          retry_d = retry_q + RC_W'(1);
          gap_d   = 1'b0;
          state_d = S_RETRY;
        end else if (i_error_con) begin
          resp_ok_d = 1'b0;
          resp_to_d = 1'b0;
          state_d   = S_RESP;
        end else if (wd_expire) begin
          resp_ok_d = 1'b0;
          resp_to_d = 1'b1;
          state_d   = S_RESP;
        end
      end

      // One idle cycle so the dispatcher can settle before the re-launch
      S_RETRY: begin
        if (!gap_q) begin
          gap_d = 1'b1;
        end else begin
          gap_d   = 1'b0;
          start_d = 1'b1;
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end

      S_RESP: begin
        if (resp_ok_q) begin
          ack_d[grant_q] = 1'b1;
        end else begin
          err_d[grant_q] = 1'b1;
          to_d           = resp_to_q;
        end
        last_d  = grant_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      last_q    <= ID_W'(N_REQ - 1);
      addr_q    <= '0;
      start_q   <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      to_q      <= 1'b0;
      busy_q    <= 1'b0;
      retry_q   <= '0;
      wd_q      <= '0;
      gap_q     <= 1'b0;
      resp_ok_q <= 1'b0;
      resp_to_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      to_q      <= to_d;
      busy_q    <= busy_d;
      retry_q   <= retry_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      resp_ok_q <= resp_ok_d;
      resp_to_q <= resp_to_d;
    end
  end

  assign o_ack        = ack_q;
  assign o_err        = err_q;
  assign o_timeout    = to_q;
  assign o_busy       = busy_q;
  assign o_grant_id   = grant_q;
  assign o_start_con  = start_q;
  assign om_base_addr = addr_q;

endmodule
